pio_bank: RTL and testbench
===========================

# pio_bank

Parametrised memory-mapped parallel I/O bank for the single-cycle RISC-V core, replacing the fixed single-port output and input pair. Sits on the data-memory bus beside the RAM, decodes a contiguous address window and supplies the register-write mux with either RAM data or I/O data. Provides N output channels with hardware pattern animation (rotate/ping-pong) and N input channels with synchronisers and rising-edge capture.

## Interface
- DATA_W, 8, width of every channel and of the bus data path
- ADDR_W, 8, bus address width
- N_OUT, 2, output channels (1..8)
- N_IN, 2, input channels (1..8)
- BASE, 8'hE0, first address of the window; window size 2*N_OUT + 2*N_IN
- TICK_W, 4, animation prescaler width; one step every 2^TICK_W clocks

- clk  in  1  system clock (divided CPU clock)
- rst  in  1  reset; synchronous and active-high
- addr  in  ADDR_W  bus address (ALU result)
- wdata  in  DATA_W  bus write data (rs2)
- we  in  1  bus write strobe (MemWrite)
- mem_rdata  in  DATA_W  read data from RAM
- rdata  out  DATA_W  read data to writeback mux
- hit  out  1  addr inside window; top level gates RAM WE with ~hit
- pin_in  in  N_IN*DATA_W  external inputs, channel k at [k*DATA_W +: DATA_W]
- pin_out  out  N_OUT*DATA_W  external outputs, same packing

## Operation
- Map (offset from BASE): 2k = OUT_DATA[k], 2k+1 = OUT_MODE[k] (bits[1:0]); 2*N_OUT+k = IN_VAL[k] (read-only); 2*N_OUT+N_IN+k = IN_EDGE[k] (write-1-to-clear).
- hit = (addr >= BASE) && (addr < BASE + window size), unsigned compare; rdata = hit ? selected register : mem_rdata. Unused OUT_MODE bits read 0.
- Output channel: pattern register drives pin_out. Write OUT_DATA loads pattern with wdata, dir := left. Read OUT_DATA returns current pattern.
- Modes on each tick: 00 static (hold); 01 rotate left 1; 10 rotate right 1; 11 ping-pong: shift in dir with zero fill; if moving left and pattern MSB already 1, flip dir to right and shift right instead; symmetric at LSB. Pattern 0 stays 0; all-ones ping-pong holds with dir toggling each tick.
- Write OUT_MODE: mode := wdata[1:0], pattern kept, dir := left.
- Prescaler: free-running TICK_W-bit counter; tick when counter == all-ones; shared by all channels.
- Input channel: two-flop synchroniser sync1→sync2, plus delay flop sync3. IN_VAL = sync2. IN_EDGE bit set when sync2 & ~sync3.
- Write to IN_EDGE: bits where wdata=1 clear; set in same cycle wins over clear.
- Write to IN_VAL or outside window: ignored.

## Timing
- Reset: all patterns, modes, dir (left), prescaler, sync1/2/3, IN_EDGE := 0; pin_out = 0, rdata = mem_rdata or 0-valued register, hit combinational.
- rdata, hit: combinational from addr, zero latency (single-cycle core).
- Writes: take effect at the clk edge where we=1; visible on pin_out and rdata the cycle after.
- Write and tick in same cycle on a channel: write wins, no shift applied that cycle.
- Input change before edge N: sync2 at edge N+1 (readable after), IN_EDGE bit at edge N+2.
- rst mid-animation: pattern and prescaler zero at that edge; no tick occurs that cycle.

## Structure
- pio_pkg: mode enum (MODE_STATIC, MODE_ROL, MODE_ROR, MODE_PINGPONG), offset helper functions, default BASE.
- Sub-module pio_out_chan (pattern, mode, dir, shift logic; inputs tick, load_data, load_mode, wdata), instantiated N_OUT times via generate; input sync and edge logic inline in pio_bank.

## Test plan
- Reset then read every window address -> all 0; addr 8'h10 with mem_rdata=8'h5A -> rdata 8'h5A, hit 0.
- Write OUT_DATA[0]=8'h81, mode 01 -> pin_out[7:0] 8'h81, 8'h03, 8'h06 on successive ticks (every 16 clk).
- Ping-pong from 8'h40 -> 8'h80, 8'h40, 8'h20 …, 8'h01, 8'h02; flip at both ends without loss.
- pin_in[1] 0→1 -> IN_VAL[1] bit after 2 edges, IN_EDGE[1] bit after 3; W1C clears; W1C same cycle as new edge keeps bit set.
- Write OUT_DATA on the tick cycle -> pattern equals wdata unshifted; rst mid-rotation -> pin_out 0 next edge.
- Sweep N_OUT=4, N_IN=1, DATA_W=16 -> map offsets and hit boundaries (BASE-1, BASE+9, BASE+10) correct.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared types and register-map helpers for the parallel I/O bank.
package pio_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'b00,
    MODE_ROL      = 2'b01,
    MODE_ROR      = 2'b10,
    MODE_PINGPONG = 2'b11
  } pio_mode_e;

  localparam logic [7:0] DEFAULT_BASE = 8'hE0;

  function automatic int unsigned out_data_off(int unsigned k);
    return 2 * k;
  endfunction

  function automatic int unsigned out_mode_off(int unsigned k);
    return 2 * k + 1;
  endfunction

  function automatic int unsigned in_val_off(int unsigned n_out, int unsigned k);
    return 2 * n_out + k;
  endfunction

  function automatic int unsigned in_edge_off(int unsigned n_out, int unsigned n_in,
                                              int unsigned k);
    return 2 * n_out + n_in + k;
  endfunction

  function automatic int unsigned win_size(int unsigned n_out, int unsigned n_in);
    return 2 * n_out + 2 * n_in;
  endfunction

endpackage

// File: rtl/pio_out_chan.sv
// One animated output channel: pattern register plus mode and ping-pong direction.
module pio_out_chan
  import pio_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              load_data_i,
  input  logic              load_mode_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] pattern_o,
  output logic [1:0]        mode_o
);

  logic [DATA_W-1:0] pattern_q, pattern_d;
  pio_mode_e         mode_q, mode_d;
  logic              dir_q, dir_d;  // 0 = moving left, 1 = moving right

  always_comb begin
    pattern_d = pattern_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    if (load_data_i) begin
      pattern_d = wdata_i;
      dir_d     = 1'b0;
    end else if (load_mode_i) begin
      mode_d = pio_mode_e'(wdata_i[1:0]);
      dir_d  = 1'b0;
    end else if (tick_i) begin
      case (mode_q)
        MODE_ROL: pattern_d = {pattern_q[DATA_W-2:0], pattern_q[DATA_W-1]};
        MODE_ROR: pattern_d = {pattern_q[0], pattern_q[DATA_W-1:1]};
        MODE_PINGPONG: begin
          // Blocked at the leading end: reverse; if blocked at both ends, just hold.
          if (!dir_q) begin
            if (!pattern_q[DATA_W-1]) begin
              pattern_d = pattern_q << 1;
            end else begin
              dir_d = 1'b1;
              if (!pattern_q[0]) pattern_d = pattern_q >> 1;
            end
          end else begin
            if (!pattern_q[0]) begin
              pattern_d = pattern_q >> 1;
            end else begin
              dir_d = 1'b0;
              if (!pattern_q[DATA_W-1]) pattern_d = pattern_q << 1;
            end
          end
        end
        default: pattern_d = pattern_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pattern_q <= '0;
      mode_q    <= MODE_STATIC;
      dir_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
    end
  end

  assign pattern_o = pattern_q;
  assign mode_o    = mode_q;

endmodule

// File: rtl/pio_bank.sv
// Memory-mapped bank of animated output channels and edge-capturing input channels.
module pio_bank
  import pio_pkg::*;
#(
  parameter int unsigned        DATA_W = 8,
  parameter int unsigned        ADDR_W = 8,
  parameter int unsigned        N_OUT  = 2,
  parameter int unsigned        N_IN   = 2,
  parameter logic [ADDR_W-1:0]  BASE   = ADDR_W'(DEFAULT_BASE),
  parameter int unsigned        TICK_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    hit,
  input  logic [N_IN*DATA_W-1:0]  pin_in,
  output logic [N_OUT*DATA_W-1:0] pin_out
);

  localparam int unsigned WIN = win_size(N_OUT, N_IN);
  localparam int unsigned INW = N_IN * DATA_W;

  logic [ADDR_W-1:0] off;
  logic              wr;
  logic              tick;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [1:0]        out_mode [N_OUT];
  logic [INW-1:0]    sync1_q, sync2_q, sync3_q;
  logic [INW-1:0]    edge_q, edge_d, clr;

  // Extra bit keeps the upper bound from wrapping when the window ends at the top.
  assign hit = ({1'b0, addr} >= {1'b0, BASE}) &&
               ({1'b0, addr} < ({1'b0, BASE} + (ADDR_W+1)'(WIN)));
  assign off = addr - BASE;
  assign wr  = we & hit;

  assign tick    = &presc_q;
  assign presc_d = presc_q + TICK_W'(1);

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    logic ld_data, ld_mode;
    assign ld_data = wr && (off == ADDR_W'(out_data_off(k)));
    assign ld_mode = wr && (off == ADDR_W'(out_mode_off(k)));

    pio_out_chan #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .tick_i     (tick),
      .load_data_i(ld_data),
      .load_mode_i(ld_mode),
      .wdata_i    (wdata),
      .pattern_o  (pin_out[k*DATA_W +: DATA_W]),
      .mode_o     (out_mode[k])
    );
  end

  always_comb begin
    clr = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (wr && (off == ADDR_W'(in_edge_off(N_OUT, N_IN, k)))) clr[k*DATA_W +: DATA_W] = wdata;
    end
    // A fresh edge overrides a clear landing in the same cycle.
    edge_d = (edge_q & ~clr) | (sync2_q & ~sync3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      edge_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= edge_d;
    end
  end

  always_comb begin
    rdata = mem_rdata;
    if (hit) begin
      rdata = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (off == ADDR_W'(out_data_off(k))) rdata = pin_out[k*DATA_W +: DATA_W];
        if (off == ADDR_W'(out_mode_off(k))) rdata = DATA_W'(out_mode[k]);
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (off == ADDR_W'(in_val_off(N_OUT, k))) rdata = sync2_q[k*DATA_W +: DATA_W];
        if (off == ADDR_W'(in_edge_off(N_OUT, N_IN, k))) rdata = edge_q[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pio_bank.sv
// Directed plus randomized bench for pio_bank against a behavioural register-map model.
module tb_pio_bank;

  localparam logic [7:0] B = 8'hE0;

  logic        clk = 1'b0;
  logic        rst, we, hit;
  logic [7:0]  addr, wdata, mem_rdata, rdata;
  logic [15:0] pin_in, pin_out;

  logic        rst2, we2, hit2;
  logic [7:0]  addr2;
  logic [15:0] wdata2, mem_rdata2, rdata2, pin_in2;
  logic [63:0] pin_out2;

  always #10 clk = ~clk;

  pio_bank #(
    .DATA_W(8), .ADDR_W(8), .N_OUT(2), .N_IN(2), .BASE(8'hE0), .TICK_W(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .mem_rdata(mem_rdata),
    .rdata(rdata), .hit(hit), .pin_in(pin_in), .pin_out(pin_out)
  );

  pio_bank #(
    .DATA_W(16), .ADDR_W(8), .N_OUT(4), .N_IN(1), .BASE(8'hE0), .TICK_W(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .addr(addr2), .wdata(wdata2), .we(we2), .mem_rdata(mem_rdata2),
    .rdata(rdata2), .hit(hit2), .pin_in(pin_in2), .pin_out(pin_out2)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: channel patterns/modes/directions, prescaler count,
  // input history (h1 newest sample .. h3 oldest) and captured edges.
  logic [7:0]  m_pat [2];
  logic [1:0]  m_md  [2];
  bit          m_dir [2];
  int          m_presc;
  logic [15:0] m_h1, m_h2, m_h3, m_edg;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  function automatic bit in_win(input logic [7:0] a);
    return (int'(a) >= int'(B)) && (int'(a) < int'(B) + 8);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    int o;
    if (!in_win(a)) return mem_rdata;
    o = int'(a) - int'(B);
    if (o < 4) return (o % 2 == 0) ? m_pat[o/2] : {6'b0, m_md[o/2]};
    if (o < 6) return m_h2[(o-4)*8 +: 8];
    return m_edg[(o-6)*8 +: 8];
  endfunction

  task automatic advance(input int k);
    logic [7:0] p;
    p = m_pat[k];
    case (m_md[k])
      2'd1: p = (p << 1) | (p >> 7);
      2'd2: p = (p >> 1) | (p << 7);
      2'd3: begin
        if (!m_dir[k]) begin
          if (p < 8'h80) p = p << 1;
          else begin m_dir[k] = 1; if (p % 2 == 0) p = p >> 1; end
        end else begin
          if (p % 2 == 0) p = p >> 1;
          else begin m_dir[k] = 0; if (p < 8'h80) p = p << 1; end
        end
      end
      default: ;
    endcase
    m_pat[k] = p;
  endtask

  task automatic model_step();
    bit tk, wr;
    int o;
    logic [15:0] clr;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin m_pat[k] = 0; m_md[k] = 0; m_dir[k] = 0; end
      m_presc = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0; m_edg = 0;
      return;
    end
    tk = (m_presc == 15);
    m_presc = (m_presc + 1) % 16;
    wr = we && in_win(addr);
    o = int'(addr) - int'(B);
    for (int k = 0; k < 2; k++) begin
      if (wr && o == 2*k) begin m_pat[k] = wdata; m_dir[k] = 0; end
      else if (wr && o == 2*k+1) begin m_md[k] = wdata[1:0]; m_dir[k] = 0; end
      else if (tk) advance(k);
    end
    clr = 0;
    if (wr && o >= 6) clr[(o-6)*8 +: 8] = wdata;
    m_edg = (m_edg & ~clr) | (m_h2 & ~m_h3);
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = pin_in;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("pin_out", pin_out, {m_pat[1], m_pat[0]});
    chk("rdata", rdata, exp_rd(addr));
    chk("hit", hit, in_win(addr));
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
    we = 0;
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wait_change(input logic [7:0] old, input int ch);
    for (int i = 0; i < 40 && pin_out[ch*8 +: 8] === old; i++) cycle();
  endtask

  task automatic sync_presc(input int target);
    for (int i = 0; i < 20 && m_presc != target; i++) cycle();
  endtask

  logic [7:0] pp_exp [10];
  logic [7:0] old;

  initial begin
    pp_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    rst = 1; we = 0; addr = 0; wdata = 0; mem_rdata = 0; pin_in = 0;
    rst2 = 1; we2 = 0; addr2 = 0; wdata2 = 0; mem_rdata2 = 0; pin_in2 = 0;
    cycle();
    cycle();
    rst = 0; rst2 = 0;

    // Reset state of every window register, then pass-through outside it.
    for (int i = 0; i < 8; i++) begin
      addr = B + 8'(i);
      cycle();
      chk("reset_rd", rdata, 8'h00);
    end
    addr = 8'h10; mem_rdata = 8'h5A;
    cycle();
    chk("passthru_rdata", rdata, 8'h5A);
    chk("passthru_hit", hit, 1'b0);

    // Rotate-left animation on channel 0.
    sync_presc(1);
    addr = B; wdata = 8'h81; we = 1; cycle();
    addr = B + 1; wdata = 8'h01; cycle();
    we = 0; addr = B;
    chk("rol_load", pin_out[7:0], 8'h81);
    wait_change(8'h81, 0);
    chk("rol_step1", pin_out[7:0], 8'h03);
    wait_change(8'h03, 0);
    chk("rol_step2", pin_out[7:0], 8'h06);

    // Ping-pong on channel 1, bouncing off both ends.
    sync_presc(1);
    addr = B + 2; wdata = 8'h40; we = 1; cycle();
    addr = B + 3; wdata = 8'h03; cycle();
    we = 0;
    for (int i = 0; i < 10; i++) begin
      old = pin_out[15:8];
      wait_change(old, 1);
      chk("pingpong", pin_out[15:8], pp_exp[i]);
    end

    // Input synchroniser latency, edge capture and write-1-to-clear.
    addr = B + 5;
    pin_in[8] = 1'b1;
    cycle();
    rd_chk(B + 5, 8'h00, "in_val_early");
    cycle();
    rd_chk(B + 5, 8'h01, "in_val");
    rd_chk(B + 7, 8'h00, "in_edge_early");
    cycle();
    rd_chk(B + 7, 8'h01, "in_edge");
    addr = B + 7; wdata = 8'h01; we = 1;
    cycle();
    rd_chk(B + 7, 8'h00, "w1c");
    pin_in[9] = 1'b1;
    cycle();
    cycle();
    addr = B + 7; wdata = 8'h02; we = 1;
    cycle();
    rd_chk(B + 7, 8'h02, "set_beats_clr");

    // Write landing on the tick cycle is taken unshifted.
    sync_presc(15);
    addr = B; wdata = 8'h3C; we = 1;
    cycle();
    we = 0;
    chk("wr_on_tick", pin_out[7:0], 8'h3C);

    // Reset in the middle of animation.
    cycle(); cycle();
    rst = 1;
    cycle();
    chk("rst_mid", pin_out, 16'h0000);
    rst = 0;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      rst = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 7);
      if (sel < 6) addr = B + 8'($urandom_range(0, 7));
      else if (sel == 6) addr = ($urandom_range(0, 1) == 0) ? B - 8'd1 : B + 8'd8;
      else addr = 8'($urandom);
      wdata = 8'($urandom);
      mem_rdata = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pin_in = 16'($urandom);
      cycle();
    end
    rst = 0; we = 0;

    // Wider configuration: 4 outputs, 1 input, 16-bit channels.
    addr2 = B - 8'd1; #1; chk("w_hit_below", hit2, 1'b0);
    addr2 = B;        #1; chk("w_hit_base", hit2, 1'b1);
    addr2 = B + 8'd9; #1; chk("w_hit_last", hit2, 1'b1);
    addr2 = B + 8'd10; #1; chk("w_hit_past", hit2, 1'b0);
    @(posedge clk); #1;
    addr2 = B + 8'd6; wdata2 = 16'hBEEF; we2 = 1;
    @(posedge clk); #1;
    addr2 = B; wdata2 = 16'h00A5;
    @(posedge clk); #1;
    we2 = 0; addr2 = B + 8'd6;
    #1;
    chk("w_out3_pin", pin_out2[63:48], 16'hBEEF);
    chk("w_out3_rd", rdata2, 16'hBEEF);
    chk("w_out0_pin", pin_out2[15:0], 16'h00A5);
    chk("w_out12_pin", pin_out2[47:16], 32'h0);
    addr2 = B + 8'd7; wdata2 = 16'hFFFE; we2 = 1;
    @(posedge clk); #1;
    we2 = 0;
    #1;
    chk("w_mode3_rd", rdata2, 16'h0002);
    pin_in2 = 16'h0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr2 = B + 8'd8; #1; chk("w_in_val", rdata2, 16'h0001);
    addr2 = B + 8'd9; #1; chk("w_in_edge", rdata2, 16'h0001);
    addr2 = 8'h20; mem_rdata2 = 16'h1234; #1;
    chk("w_passthru", rdata2, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
